// File: rtl/vga_timing_if.sv
// Purpose : bundles the run enable and all raster timing outputs of vga_timing_gen.
// Latency : none, wires only.
// Backpressure: none; the consumer can only pause the raster through i_en.
//
// master : the timing generator (drives timing, samples i_en)
// slave  : the framebuffer reader / DAC driver (drives i_en, samples timing)
// CNT_W and FRAME_W must match the generator instance connected to it.
interface vga_timing_if #(
  parameter int CNT_W   = 11,
  parameter int FRAME_W = 8
);
  logic               i_en;
  logic               o_pix_tick;
  logic               o_hs;
  logic               o_vs;
  logic               o_sync_n;
  logic               o_blank_n;
  logic               o_de;
  logic [CNT_W-1:0]   o_x;
  logic [CNT_W-1:0]   o_y;
  logic               o_line_start;
  logic               o_frame_start;
  logic [FRAME_W-1:0] o_frame_cnt;

  modport master (
    input  i_en,
    output o_pix_tick, o_hs, o_vs, o_sync_n, o_blank_n, o_de,
    output o_x, o_y, o_line_start, o_frame_start, o_frame_cnt
  );

  modport slave (
    output i_en,
    input  o_pix_tick, o_hs, o_vs, o_sync_n, o_blank_n, o_de,
    input  o_x, o_y, o_line_start, o_frame_start, o_frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Purpose : parametrised raster timing generator (sync, blanking, DE, x/y, strobes, frame count).
// Latency : all outputs registered; they reflect the counter state reached on the same edge.
// Backpressure: i_en low freezes divider, counters and levels; strobes are forced low.
//
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_rst_n  synchronous active-low reset, overrides i_en
//   vif      vga_timing_if.master: i_en in; o_pix_tick, o_hs, o_vs, o_sync_n,
//            o_blank_n, o_de, o_x, o_y, o_line_start, o_frame_start, o_frame_cnt out
// Line layout per counter: sync, back porch, active, front porch (sync at count 0).
module vga_timing_gen #(
  parameter int CNT_W    = 11,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int FRAME_W  = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  vga_timing_if.master vif
);

  localparam int HMAX    = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VMAX    = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(HMAX - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(VMAX - 1);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (longint'(HMAX - 1) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_hmax
    $error("vga_timing_gen: horizontal total does not fit in CNT_W bits");
  end
  if (longint'(VMAX - 1) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_vmax
    $error("vga_timing_gen: vertical total does not fit in CNT_W bits");
  end

  // Timing state
  logic [DIV_W-1:0]   div, div_nxt;
  logic [CNT_W-1:0]   hc, hc_nxt;
  logic [CNT_W-1:0]   vc, vc_nxt;
  logic [FRAME_W-1:0] frame_cnt, frame_cnt_nxt;

  // Output registers
  logic               tick_q, hs_q, vs_q, blank_n_q, line_q, frame_q;
  logic [CNT_W-1:0]   x_q, y_q;

  // Next-state decode
  logic               tick, h_wrap, v_wrap;
  logic               h_act, v_act, hs_nxt, vs_nxt;
  logic [CNT_W-1:0]   x_nxt, y_nxt;

  always_comb begin
    div_nxt       = div;
    hc_nxt        = hc;
    vc_nxt        = vc;
    frame_cnt_nxt = frame_cnt;
    tick          = 1'b0;
    h_wrap        = 1'b0;
    v_wrap        = 1'b0;

    if (vif.i_en) begin
      if (div == DIV_LAST) begin
        div_nxt = '0;
        tick    = 1'b1;
      end else begin
        div_nxt = div + DIV_W'(1);
      end
    end

    if (tick) begin
      if (hc == H_LAST) begin
        hc_nxt = '0;
        h_wrap = 1'b1;
        if (vc == V_LAST) begin
          vc_nxt        = '0;
          v_wrap        = 1'b1;
          frame_cnt_nxt = frame_cnt + FRAME_W'(1);
        end else begin
          vc_nxt = vc + CNT_W'(1);
        end
      end else begin
        hc_nxt = hc + CNT_W'(1);
      end
    end

    // Levels are decoded from the counters being loaded this edge, so the
    // registered outputs line up with (hc, vc) rather than lagging a pixel.
    hs_nxt = (int'(hc_nxt) < H_SYNC) ? H_POL : ~H_POL;
    vs_nxt = (int'(vc_nxt) < V_SYNC) ? V_POL : ~V_POL;
    h_act  = (int'(hc_nxt) >= H_START) && (int'(hc_nxt) < H_END);
    v_act  = (int'(vc_nxt) >= V_START) && (int'(vc_nxt) < V_END);
    x_nxt  = (h_act && v_act) ? (hc_nxt - H_START_C) : '0;
    y_nxt  = (h_act && v_act) ? (vc_nxt - V_START_C) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div       <= '0;
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
      tick_q    <= 1'b0;
      hs_q      <= H_POL;
      vs_q      <= V_POL;
      blank_n_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      div       <= div_nxt;
      hc        <= hc_nxt;
      vc        <= vc_nxt;
      frame_cnt <= frame_cnt_nxt;
      tick_q    <= tick;
      hs_q      <= hs_nxt;
      vs_q      <= vs_nxt;
      blank_n_q <= h_act && v_act;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      line_q    <= h_wrap;
      // v_wrap only rises together with h_wrap, so a frame strobe always
      // coincides with a line strobe.
      frame_q   <= v_wrap;
    end
  end

  assign vif.o_pix_tick    = tick_q;
  assign vif.o_hs          = hs_q;
  assign vif.o_vs          = vs_q;
  assign vif.o_sync_n      = 1'b0;
  assign vif.o_blank_n     = blank_n_q;
  assign vif.o_de          = blank_n_q;
  assign vif.o_x           = x_q;
  assign vif.o_y           = y_q;
  assign vif.o_line_start  = line_q;
  assign vif.o_frame_start = frame_q;
  assign vif.o_frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : checks two generator instances (default 640x480 and a tiny polarity-inverted raster).
// Latency : expectations are stamped with the i_clk edge count after which they must hold.
// Backpressure: i_en is dropped mid-line on the default instance to check the freeze.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_if #(.CNT_W(11), .FRAME_W(8)) a_if ();
  vga_timing_if #(.CNT_W(4),  .FRAME_W(2)) b_if ();

  vga_timing_gen dut_a (
    .i_clk  (clk),
    .i_rst_n(rst_a_n),
    .vif    (a_if)
  );

  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .FRAME_W(2)
  ) dut_b (
    .i_clk  (clk),
    .i_rst_n(rst_b_n),
    .vif    (b_if)
  );

  typedef struct {
    int    cyc;
    string name;
    logic  tick, hs, vs, bl;
    int    x, y;
    logic  ls, fs;
    int    fc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;
  bit   drain = 1'b0;
  bit   drained = 1'b0;

  task automatic push(input bit which, input int c, input string n,
                      input logic tk, input logic hs, input logic vs, input logic bl,
                      input int x, input int y, input logic ls, input logic fs, input int fc);
    exp_t e;
    e.cyc = c; e.name = n; e.tick = tk; e.hs = hs; e.vs = vs; e.bl = bl;
    e.x = x; e.y = y; e.ls = ls; e.fs = fs; e.fc = fc;
    if (which) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  task automatic check(input exp_t e, input logic tk, input logic hs, input logic vs,
                       input logic bl, input logic de, input logic sn, input int x,
                       input int y, input logic ls, input logic fs, input int fc);
    bit ok;
    ok = (tk === e.tick) && (hs === e.hs) && (vs === e.vs) && (bl === e.bl) &&
         (de === e.bl) && (sn === 1'b0) && (x == e.x) && (y == e.y) &&
         (ls === e.ls) && (fs === e.fs) && (fc == e.fc) && (e.cyc == cyc);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s @%0d: got tick=%b hs=%b vs=%b bl=%b de=%b sn=%b x=%0d y=%0d ls=%b fs=%b fc=%0d, want @%0d tick=%b hs=%b vs=%b bl=%b de=%b sn=0 x=%0d y=%0d ls=%b fs=%b fc=%0d",
               e.name, cyc, tk, hs, vs, bl, de, sn, x, y, ls, fs, fc,
               e.cyc, e.tick, e.hs, e.vs, e.bl, e.bl, e.x, e.y, e.ls, e.fs, e.fc);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      check(e, a_if.o_pix_tick, a_if.o_hs, a_if.o_vs, a_if.o_blank_n, a_if.o_de,
            a_if.o_sync_n, int'(a_if.o_x), int'(a_if.o_y), a_if.o_line_start,
            a_if.o_frame_start, int'(a_if.o_frame_cnt));
    end
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      check(e, b_if.o_pix_tick, b_if.o_hs, b_if.o_vs, b_if.o_blank_n, b_if.o_de,
            b_if.o_sync_n, int'(b_if.o_x), int'(b_if.o_y), b_if.o_line_start,
            b_if.o_frame_start, int'(b_if.o_frame_cnt));
    end
    if (drain && !drained) begin
      while (qa.size() > 0) begin
        e = qa.pop_front(); tests++; fails++;
        $display("FAIL %s: expectation for edge %0d never reached (now %0d)", e.name, e.cyc, cyc);
      end
      while (qb.size() > 0) begin
        e = qb.pop_front(); tests++; fails++;
        $display("FAIL %s: expectation for edge %0d never reached (now %0d)", e.name, e.cyc, cyc);
      end
      drained = 1'b1;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Default instance: reset released after edge 5, so pixel tick n lands on
  // edge 5+2n and hc = n mod 800, vc = n / 800.  L is the edge that starts vc=35.
  localparam int L = 5 + 56000;

  initial begin
    a_if.i_en = 1'b1;
    b_if.i_en = 1'b1;

    //        which cyc     name             tk  hs  vs  bl  x    y  ls  fs fc
    push(0, 5,       "a_reset",       0,  0,  0,  0,  0,   0, 0,  0, 0);
    push(0, 6,       "a_no_tick_e1",  0,  0,  0,  0,  0,   0, 0,  0, 0);
    push(0, 7,       "a_first_tick",  1,  0,  0,  0,  0,   0, 0,  0, 0);
    push(0, 195,     "a_hs_hc95",     1,  0,  0,  0,  0,   0, 0,  0, 0);
    push(0, 197,     "a_hs_hc96",     1,  1,  0,  0,  0,   0, 0,  0, 0);
    push(0, 1605,    "a_line_start",  1,  0,  0,  0,  0,   0, 1,  0, 0);
    push(0, 1606,    "a_line_off",    0,  0,  0,  0,  0,   0, 0,  0, 0);
    push(0, 3205,    "a_vs_vc2",      1,  0,  1,  0,  0,   0, 1,  0, 0);
    push(0, L,       "a_vc35_start",  1,  0,  1,  0,  0,   0, 1,  0, 0);
    push(0, L+286,   "a_hc143",       1,  1,  1,  0,  0,   0, 0,  0, 0);
    push(0, L+288,   "a_hc144",       1,  1,  1,  1,  0,   0, 0,  0, 0);
    push(0, L+290,   "a_hc145",       1,  1,  1,  1,  1,   0, 0,  0, 0);

    push(1, 10,  "b_reset",      0, 1, 1, 0, 0, 0, 0, 0, 0);
    push(1, 11,  "b_tick1",      1, 1, 1, 0, 0, 0, 0, 0, 0);
    push(1, 12,  "b_hs_off",     1, 0, 1, 0, 0, 0, 0, 0, 0);
    push(1, 18,  "b_line8",      1, 1, 0, 0, 0, 0, 1, 0, 0);
    push(1, 29,  "b_act_first",  1, 0, 0, 1, 0, 0, 0, 0, 0);
    push(1, 32,  "b_act_last",   1, 0, 0, 1, 3, 0, 0, 0, 0);
    push(1, 33,  "b_fp",         1, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1, 46,  "b_x1_y2",      1, 0, 0, 1, 1, 2, 0, 0, 0);
    push(1, 58,  "b_frame1",     1, 1, 1, 0, 0, 0, 1, 1, 1);
    push(1, 59,  "b_frame1_off", 1, 1, 1, 0, 0, 0, 0, 0, 1);
    push(1, 106, "b_frame2",     1, 1, 1, 0, 0, 0, 1, 1, 2);
    push(1, 154, "b_frame3",     1, 1, 1, 0, 0, 0, 1, 1, 3);
    push(1, 202, "b_fc_wrap",    1, 1, 1, 0, 0, 0, 1, 1, 0);
    push(1, 203, "b_wrap_off",   1, 1, 1, 0, 0, 0, 0, 0, 0);
    push(1, 279, "b_pre_reset",  1, 0, 0, 1, 2, 1, 0, 0, 1);

    wait_cyc(5);
    rst_a_n = 1'b1;
    wait_cyc(10);
    rst_b_n = 1'b1;

    wait_cyc(279);
    push(1, 280, "b_mid_reset",  0, 1, 1, 0, 0, 0, 0, 0, 0);
    push(1, 281, "b_post_reset", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    rst_b_n = 1'b0;
    wait_cyc(280);
    rst_b_n = 1'b1;

    // Freeze for 37 edges starting with the divider half way (hc=300, x=156).
    wait_cyc(L+601);
    push(0, L+601, "a_pre_hold", 0, 1, 1, 1, 156, 0, 0, 0, 0);
    for (int i = L+602; i <= L+638; i++)
      push(0, i, "a_hold", 0, 1, 1, 1, 156, 0, 0, 0, 0);
    push(0, L+639,  "a_resume",      1, 1, 1, 1, 157, 0, 0, 0, 0);
    push(0, L+640,  "a_resume_half", 0, 1, 1, 1, 157, 0, 0, 0, 0);
    push(0, L+1603, "a_hc783",       1, 1, 1, 1, 639, 0, 0, 0, 0);
    push(0, L+1605, "a_hc784",       1, 1, 1, 0, 0,   0, 0, 0, 0);
    push(0, L+1637, "a_vc36_start",  1, 0, 1, 0, 0,   0, 1, 0, 0);
    push(0, L+1925, "a_vc36_hc144",  1, 1, 1, 1, 0,   1, 0, 0, 0);
    push(0, L+2637, "a_hc500",       1, 1, 1, 1, 356, 1, 0, 0, 0);
    a_if.i_en = 1'b0;
    wait_cyc(L+638);
    a_if.i_en = 1'b1;

    wait_cyc(L+2637);
    push(0, L+2638, "a_mid_reset",   0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(0, L+2639, "a_reset_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(0, L+2640, "a_rel_e1",      0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(0, L+2641, "a_rel_tick",    1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_a_n = 1'b0;
    wait_cyc(L+2639);
    rst_a_n = 1'b1;

    wait_cyc(L+2660);
    drain = 1'b1;
    for (int i = 0; i < 10 && !drained; i++) @(posedge clk);
    if (!drained) begin
      tests++;
      fails++;
      $display("FAIL drain: monitor did not flush, drained=%b want 1", drained);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
